// File: rtl/conv_channel_accumulator_if.sv
// rtl/conv_channel_accumulator_if.sv - beat input and group result signals of the channel accumulator
interface conv_channel_accumulator_if #(
    parameter int B = 8,
    parameter int C = 10,
    parameter int N = 3
) ();
    logic             in_valid;
    logic [N*B-1:0]   in_data;
    logic [C-1:0]     bias;
    logic             out_valid;
    logic [C-1:0]     out_data;
    logic             out_sat;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        output bias,
        input  out_valid,
        input  out_data,
        input  out_sat,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  bias,
        output out_valid,
        output out_data,
        output out_sat,
        output busy
    );
endinterface

// File: rtl/conv_channel_accumulator.sv
// rtl/conv_channel_accumulator.sv - N-channel beat reduction with PASSES-beat biased accumulation
module conv_channel_accumulator #(
    parameter int B      = 8,
    parameter int C      = 10,
    parameter int N      = 3,
    parameter int PASSES = 4,
    parameter bit SAT    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    conv_channel_accumulator_if.slave bus
);
    localparam int SW  = B + $clog2(N) + 1;
    localparam int AW0 = SW + $clog2(PASSES);
    localparam int AW  = ((AW0 > C) ? AW0 : C) + 1;
    localparam int CW  = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [CW-1:0]        CNT_LAST = CW'(PASSES - 1);
    localparam logic signed [AW-1:0] MAX_V    = {{(AW-C+1){1'b0}}, {(C-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V    = {{(AW-C+1){1'b1}}, {(C-1){1'b0}}};

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_first_q, s1_first_d;
    logic                 s1_last_q, s1_last_d;
    logic signed [SW-1:0] s1_sum_q, s1_sum_d;
    logic signed [AW-1:0] s1_bias_q, s1_bias_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic [C-1:0]         out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;

    logic                 first;
    logic                 last;
    logic signed [SW-1:0] beat_sum;
    logic signed [B-1:0]  chan;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] acc_next;
    logic                 over;
    logic                 under;
    logic [C-1:0]         fmt_data;

    always_comb begin
        first    = (cnt_q == '0);
        last     = (cnt_q == CNT_LAST);
        beat_sum = '0;
        chan     = '0;
        for (int i = 0; i < N; i++) begin
            chan     = bus.in_data[i*B +: B];
            beat_sum = beat_sum + {{(SW-B){chan[B-1]}}, chan};
        end
    end

    // Stage 0/1: counter and beat register move only on accepted beats.
    always_comb begin
        cnt_d      = cnt_q;
        s1_valid_d = bus.in_valid;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_sum_d   = s1_sum_q;
        s1_bias_d  = s1_bias_q;
        if (bus.in_valid) begin
            cnt_d      = last ? '0 : cnt_q + CW'(1);
            s1_first_d = first;
            s1_last_d  = last;
            s1_sum_d   = beat_sum;
            if (first) begin
                s1_bias_d = {{(AW-C){bus.bias[C-1]}}, bus.bias};
            end
        end
    end

    // Stage 2: a first beat reloads from bias so back-to-back groups stay independent.
    always_comb begin
        acc_base = s1_first_q ? s1_bias_q : acc_q;
        acc_next = acc_base + {{(AW-SW){s1_sum_q[SW-1]}}, s1_sum_q};
        over     = (acc_next > MAX_V);
        under    = (acc_next < MIN_V);
        if (SAT) begin
            fmt_data = over ? MAX_V[C-1:0] : (under ? MIN_V[C-1:0] : acc_next[C-1:0]);
        end else begin
            fmt_data = acc_next[C-1:0];
        end

        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (s1_valid_q) begin
            acc_d = acc_next;
            if (s1_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = fmt_data;
                out_sat_d   = over | under;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            s1_bias_q   <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_sum_q    <= s1_sum_d;
            s1_bias_q   <= s1_bias_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    // busy covers the pulse cycle itself so it drops the cycle after out_valid.
    assign bus.busy      = (cnt_q != '0) | s1_valid_q | out_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_conv_channel_accumulator.sv
// tb/tb_conv_channel_accumulator.sv - randomized self-checking bench for conv_channel_accumulator
module tb_conv_channel_accumulator;
    localparam int PASSES = 4;

    typedef struct packed {
        int                 cyc;
        logic signed [9:0]  data;
        logic               sat;
        logic               busy;
    } res_t;

    typedef struct {
        bit rst;
        bit v;
        int c0;
        int c1;
        int c2;
        int bias;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic [9:0]  bias = '0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          mcnt = 0;
    int          msum = 0;
    res_t        exp_s[$];
    res_t        exp_w[$];
    res_t        obs_s[$];
    res_t        obs_w[$];

    conv_channel_accumulator_if #(.B(8), .C(10), .N(3)) sat_if ();
    conv_channel_accumulator_if #(.B(8), .C(10), .N(3)) wrap_if ();

    assign sat_if.in_valid  = in_valid;
    assign sat_if.in_data   = in_data;
    assign sat_if.bias      = bias;
    assign wrap_if.in_valid = in_valid;
    assign wrap_if.in_data  = in_data;
    assign wrap_if.bias     = bias;

    conv_channel_accumulator #(.B(8), .C(10), .N(3), .PASSES(PASSES), .SAT(1'b1)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sat_if.slave)
    );

    conv_channel_accumulator #(.B(8), .C(10), .N(3), .PASSES(PASSES), .SAT(1'b0)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wrap_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sat_if.out_valid === 1'b1)
            obs_s.push_back('{cyc, sat_if.out_data, sat_if.out_sat, sat_if.busy});
        if (wrap_if.out_valid === 1'b1)
            obs_w.push_back('{cyc, wrap_if.out_data, wrap_if.out_sat, wrap_if.busy});
    end

    // Result of one group: exact sum formatted into 10 signed bits.
    function automatic res_t mk(int at, int v, bit sat_mode);
        res_t r;
        r.cyc  = at;
        r.busy = 1'b1;
        r.sat  = (v > 511) || (v < -512);
        if (sat_mode && v > 511)       r.data = 10'sd511;
        else if (sat_mode && v < -512) r.data = -10'sd512;
        else                           r.data = 10'(v);
        return r;
    endfunction

    function automatic beat_t bt(bit r, bit v, int a, int b, int c, int bs);
        beat_t x;
        x.rst = r; x.v = v; x.c0 = a; x.c1 = b; x.c2 = c; x.bias = bs;
        return x;
    endfunction

    function automatic int rch();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic int rbias();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    // Drive a beat list; a pulse is expected two edges after the last beat's edge.
    task automatic play(input beat_t seq[$]);
        foreach (seq[k]) begin
            @(negedge clk);
            rst_n    = seq[k].rst;
            in_valid = seq[k].v;
            in_data  = {8'(seq[k].c2), 8'(seq[k].c1), 8'(seq[k].c0)};
            bias     = 10'(seq[k].bias);
            if (seq[k].rst) begin
                while (exp_s.size() > 0 && exp_s[$].cyc >= cyc + 1) void'(exp_s.pop_back());
                while (exp_w.size() > 0 && exp_w[$].cyc >= cyc + 1) void'(exp_w.pop_back());
                mcnt = 0;
            end else if (seq[k].v) begin
                if (mcnt == 0) msum = seq[k].bias;
                msum = msum + seq[k].c0 + seq[k].c1 + seq[k].c2;
                mcnt++;
                if (mcnt == PASSES) begin
                    exp_s.push_back(mk(cyc + 2, msum, 1'b1));
                    exp_w.push_back(mk(cyc + 2, msum, 1'b0));
                    mcnt = 0;
                end
            end
        end
        repeat (5) begin
            @(negedge clk);
            rst_n = 1'b0; in_valid = 1'b0; in_data = 24'($urandom); bias = 10'($urandom);
        end
    endtask

    task automatic clear_q();
        exp_s.delete(); exp_w.delete(); obs_s.delete(); obs_w.delete();
    endtask

    function automatic beat_t basic(int k);
        case (k)
            0:       return bt(0, 1, 1, 2, 3, 5);
            1:       return bt(0, 1, 4, 5, 6, rbias());
            2:       return bt(0, 1, -1, -2, -3, rbias());
            default: return bt(0, 1, 10, 0, 0, rbias());
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b1;
        repeat (2) begin
            in_data = 24'($urandom);
            @(negedge clk);
            vectors += 4;
            if (sat_if.out_valid !== 1'b0 || sat_if.out_data !== 10'd0 || sat_if.out_sat !== 1'b0 || sat_if.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_sat: got v=%b d=%0d s=%b busy=%b, want all 0", sat_if.out_valid, sat_if.out_data, sat_if.out_sat, sat_if.busy);
            end
            if (wrap_if.out_valid !== 1'b0 || wrap_if.out_data !== 10'd0 || wrap_if.out_sat !== 1'b0 || wrap_if.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_wrap: got v=%b d=%0d s=%b busy=%b, want all 0", wrap_if.out_valid, wrap_if.out_data, wrap_if.out_sat, wrap_if.busy);
            end
        end
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        beat_t seq[$];
        clear_q();
        for (int k = 0; k < 4; k++) seq.push_back(basic(k));
        play(seq);
        vectors += 3;
        if (obs_s.size() != 1 || obs_w.size() != 1) begin
            miscompares++;
            $display("FAIL basic_count: got %0d/%0d pulses, want 1/1", obs_s.size(), obs_w.size());
        end else begin
            if (obs_s[0] !== exp_s[0] || obs_s[0].data !== 10'sd30) begin
                miscompares++;
                $display("FAIL basic_sat: got cyc=%0d d=%0d s=%b b=%b, want cyc=%0d d=30 s=0 b=1", obs_s[0].cyc, obs_s[0].data, obs_s[0].sat, obs_s[0].busy, exp_s[0].cyc);
            end
            if (obs_w[0] !== exp_w[0]) begin
                miscompares++;
                $display("FAIL basic_wrap: got cyc=%0d d=%0d s=%b, want cyc=%0d d=%0d s=%b", obs_w[0].cyc, obs_w[0].data, obs_w[0].sat, exp_w[0].cyc, exp_w[0].data, exp_w[0].sat);
            end
        end
        vectors++;
        if (sat_if.busy !== 1'b0 || sat_if.out_data !== 10'd30) begin
            miscompares++;
            $display("FAIL basic_idle: got busy=%b held=%0d, want busy=0 held=30", sat_if.busy, sat_if.out_data);
        end
    endtask

    task automatic test_saturation();
        beat_t seq[$];
        clear_q();
        for (int k = 0; k < 4; k++) seq.push_back(bt(0, 1, 127, 127, 127, (k == 0) ? 0 : rbias()));
        seq.push_back(bt(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) seq.push_back(bt(0, 1, -128, -128, -128, (k == 0) ? -512 : rbias()));
        play(seq);
        vectors += 5;
        if (obs_s.size() != 2 || obs_w.size() != 2) begin
            miscompares++;
            $display("FAIL sat_count: got %0d/%0d pulses, want 2/2", obs_s.size(), obs_w.size());
        end else begin
            if (obs_s[0].data !== 10'sd511 || obs_s[0].sat !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_pos: got d=%0d s=%b, want d=511 s=1", obs_s[0].data, obs_s[0].sat);
            end
            if (obs_s[1].data !== -10'sd512 || obs_s[1].sat !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_neg: got d=%0d s=%b, want d=-512 s=1", obs_s[1].data, obs_s[1].sat);
            end
            if (obs_w[0].data !== 10'sd500 || obs_w[0].sat !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_pos: got d=%0d s=%b, want d=500 s=1", obs_w[0].data, obs_w[0].sat);
            end
            if (obs_w[1] !== exp_w[1] || obs_s[1].cyc !== exp_s[1].cyc) begin
                miscompares++;
                $display("FAIL wrap_neg: got cyc=%0d d=%0d s=%b, want cyc=%0d d=%0d s=%b", obs_w[1].cyc, obs_w[1].data, obs_w[1].sat, exp_w[1].cyc, exp_w[1].data, exp_w[1].sat);
            end
        end
    endtask

    task automatic test_gaps();
        beat_t seq[$];
        clear_q();
        for (int k = 0; k < 4; k++) begin
            seq.push_back(basic(k));
            if (k < 3) repeat (3) seq.push_back(bt(0, 0, rch(), rch(), rch(), rbias()));
        end
        play(seq);
        vectors += 2;
        if (obs_s.size() != 1 || obs_w.size() != 1) begin
            miscompares++;
            $display("FAIL gaps_count: got %0d/%0d pulses, want 1/1", obs_s.size(), obs_w.size());
        end else if (obs_s[0] !== exp_s[0] || obs_s[0].data !== 10'sd30 || obs_w[0] !== exp_w[0]) begin
            miscompares++;
            $display("FAIL gaps_result: got cyc=%0d d=%0d s=%b, want cyc=%0d d=30 s=0", obs_s[0].cyc, obs_s[0].data, obs_s[0].sat, exp_s[0].cyc);
        end
    endtask

    task automatic test_back_to_back();
        beat_t seq[$];
        clear_q();
        for (int k = 0; k < 4; k++) seq.push_back(basic(k));
        for (int k = 0; k < 4; k++) seq.push_back(bt(0, 1, 1, 1, 1, (k == 0) ? -2 : rbias()));
        play(seq);
        vectors += 3;
        if (obs_s.size() != 2 || obs_w.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d/%0d pulses, want 2/2", obs_s.size(), obs_w.size());
        end else begin
            if (obs_s[0].data !== 10'sd30 || obs_s[1].data !== 10'sd10) begin
                miscompares++;
                $display("FAIL b2b_values: got %0d,%0d, want 30,10", obs_s[0].data, obs_s[1].data);
            end
            if (obs_s[1].cyc - obs_s[0].cyc !== 4 || obs_s[0] !== exp_s[0] || obs_w[1] !== exp_w[1]) begin
                miscompares++;
                $display("FAIL b2b_timing: got cycles %0d,%0d, want %0d,%0d", obs_s[0].cyc, obs_s[1].cyc, exp_s[0].cyc, exp_s[1].cyc);
            end
        end
    endtask

    task automatic test_reset_mid_group();
        beat_t seq[$];
        clear_q();
        seq.push_back(bt(0, 1, 50, 50, 50, rbias()));
        seq.push_back(bt(0, 1, 50, 50, 50, rbias()));
        seq.push_back(bt(1, 1, rch(), rch(), rch(), rbias()));
        for (int k = 0; k < 4; k++) seq.push_back(basic(k));
        // A reset right behind a last beat must swallow that pulse.
        for (int k = 0; k < 4; k++) seq.push_back(bt(0, 1, rch(), rch(), rch(), rbias()));
        seq.push_back(bt(1, 0, 0, 0, 0, 0));
        play(seq);
        vectors += 2;
        if (obs_s.size() != 1 || obs_w.size() != 1) begin
            miscompares++;
            $display("FAIL rstmid_count: got %0d/%0d pulses, want 1/1", obs_s.size(), obs_w.size());
        end else if (obs_s[0] !== exp_s[0] || obs_s[0].data !== 10'sd30 || obs_w[0] !== exp_w[0]) begin
            miscompares++;
            $display("FAIL rstmid_result: got cyc=%0d d=%0d, want cyc=%0d d=30", obs_s[0].cyc, obs_s[0].data, exp_s[0].cyc);
        end
        vectors++;
        if (sat_if.out_data !== 10'd0 || sat_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_clear: got held=%0d busy=%b, want 0 0", sat_if.out_data, sat_if.busy);
        end
    endtask

    task automatic test_random();
        beat_t seq[$];
        clear_q();
        for (int g = 0; g < 12; g++) begin
            for (int k = 0; k < PASSES; k++) begin
                repeat ($urandom_range(0, 2)) seq.push_back(bt(0, 0, rch(), rch(), rch(), rbias()));
                seq.push_back(bt(0, 1, rch(), rch(), rch(), rbias()));
            end
        end
        play(seq);
        vectors++;
        if (obs_s.size() != exp_s.size() || obs_w.size() != exp_w.size()) begin
            miscompares++;
            $display("FAIL rand_count: got %0d/%0d pulses, want %0d", obs_s.size(), obs_w.size(), exp_s.size());
        end
        for (int k = 0; k < exp_s.size() && k < obs_s.size() && k < obs_w.size(); k++) begin
            vectors += 2;
            if (obs_s[k] !== exp_s[k]) begin
                miscompares++;
                $display("FAIL rand_sat[%0d]: got cyc=%0d d=%0d s=%b, want cyc=%0d d=%0d s=%b", k, obs_s[k].cyc, obs_s[k].data, obs_s[k].sat, exp_s[k].cyc, exp_s[k].data, exp_s[k].sat);
            end
            if (obs_w[k] !== exp_w[k]) begin
                miscompares++;
                $display("FAIL rand_wrap[%0d]: got cyc=%0d d=%0d s=%b, want cyc=%0d d=%0d s=%b", k, obs_w[k].cyc, obs_w[k].data, obs_w[k].sat, exp_w[k].cyc, exp_w[k].data, exp_w[k].sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_gaps();
        test_back_to_back();
        test_reset_mid_group();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1);
    end
endmodule
